// File: rtl/jtag_fifo_ctrl_sync_v2.sv
// jtag_fifo_ctrl_sync_v2: single-clock FIFO pointer/flag controller with width ratio, FWFT and sticky errors.
module jtag_fifo_ctrl_sync_v2 #(
    parameter int    c_WR_DEPTH_WIDTH   = 9,
    parameter int    c_RD_DEPTH_WIDTH   = 9,
    parameter string c_RD_MODE          = "STD",
    parameter int    c_PROG_THRESH      = 0,
    parameter int    c_ALMOST_FULL_NUM  = 508,
    parameter int    c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    output logic [c_WR_DEPTH_WIDTH-1:0] waddr,
    output logic                        ram_wr_en,
    output logic                        wfull,
    output logic                        almost_full,
    output logic [c_WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic                        r_en,
    output logic [c_RD_DEPTH_WIDTH-1:0] raddr,
    output logic                        ram_rd_en,
    output logic                        rempty,
    output logic                        almost_empty,
    output logic [c_RD_DEPTH_WIDTH:0]   rd_water_level,
    input  logic [c_WR_DEPTH_WIDTH:0]   af_level,
    input  logic [c_RD_DEPTH_WIDTH:0]   ae_level,
    input  logic                        err_clr,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int W = c_WR_DEPTH_WIDTH;
    localparam int R = c_RD_DEPTH_WIDTH;
    localparam int N = (W > R) ? W : R;
    localparam int D = (W > R) ? W - R : R - W;
    localparam bit FWFT = (c_RD_MODE == "FWFT");
    localparam logic [W:0] AF_NUM = (W+1)'(c_ALMOST_FULL_NUM);
    localparam logic [R:0] AE_NUM = (R+1)'(c_ALMOST_EMPTY_NUM);

    logic [W:0] wbin, wbin_n, r_on_w, wr_lvl_n, af_thr;
    logic [R:0] rbin, rbin_n, w_on_r, core_lvl_n, rd_lvl_n, ae_thr;
    logic [N:0] wx, rx;
    logic       core_empty, out_valid, out_valid_n;

    assign waddr     = wbin[W-1:0];
    assign raddr     = rbin[R-1:0];
    assign ram_wr_en = w_en & !wfull;
    assign rempty    = FWFT ? !out_valid : core_empty;
    assign ram_rd_en = FWFT ? !core_empty & (!out_valid | r_en) : r_en & !core_empty;
    assign out_valid_n = FWFT & (ram_rd_en | (out_valid & !r_en));
    assign wbin_n    = wbin + (W+1)'(ram_wr_en);
    assign rbin_n    = rbin + (R+1)'(ram_rd_en);
    // Shallower pointer is shifted up, deeper one truncated, so partial wide words never count as readable.
    assign wx        = (N+1)'(wbin_n);
    assign rx        = (N+1)'(rbin_n);
    assign r_on_w    = (W+1)'((R > W) ? rx >> D : rx << D);
    assign w_on_r    = (R+1)'((W > R) ? wx >> D : wx << D);
    assign wr_lvl_n  = wbin_n - r_on_w;
    assign core_lvl_n = w_on_r - rbin_n;
    assign rd_lvl_n  = core_lvl_n + (R+1)'(out_valid_n);
    assign af_thr    = (c_PROG_THRESH != 0) ? af_level : AF_NUM;
    assign ae_thr    = (c_PROG_THRESH != 0) ? ae_level : AE_NUM;

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin           <= '0;
            rbin           <= '0;
            out_valid      <= 1'b0;
            core_empty     <= 1'b1;
            wfull          <= 1'b0;
            almost_full    <= 1'b0;
            almost_empty   <= 1'b1;
            wr_water_level <= '0;
            rd_water_level <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            wbin           <= wbin_n;
            rbin           <= rbin_n;
            out_valid      <= out_valid_n;
            core_empty     <= (core_lvl_n == '0);
            wfull          <= (wr_lvl_n == {1'b1, {W{1'b0}}});
            almost_full    <= (wr_lvl_n >= af_thr);
            almost_empty   <= (rd_lvl_n <= ae_thr);
            wr_water_level <= wr_lvl_n;
            rd_water_level <= rd_lvl_n;
            overflow       <= (overflow & !err_clr) | (w_en & wfull);
            underflow      <= (underflow & !err_clr) | (r_en & rempty);
        end
    end
endmodule

// File: tb/tb_jtag_fifo_ctrl_sync_v2.sv
// tb_jtag_fifo_ctrl_sync_v2: directed checks over STD, 2:1, FWFT/programmable and wrap configurations.
module tb_jtag_fifo_ctrl_sync_v2;
    logic clk = 1'b0;
    logic rst = 1'b0, w_en = 1'b0, r_en = 1'b0, err_clr = 1'b0;
    logic [4:0] af_lvl = 5'd10, ae_lvl = 5'd4;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    logic [8:0] waddr0, raddr0;
    logic [9:0] wl0, rl0;
    logic wre0, wfull0, af0, rre0, rempty0, ae0, ovf0, udf0;
    logic [9:0] waddr1, rl1;
    logic [8:0] raddr1;
    logic [10:0] wl1;
    logic wre1, wfull1, af1, rre1, rempty1, ae1, ovf1, udf1;
    logic [3:0] waddr2, raddr2, waddr3, raddr3;
    logic [4:0] wl2, rl2, wl3, rl3;
    logic wre2, wfull2, af2, rre2, rempty2, ae2, ovf2, udf2;
    logic wre3, wfull3, af3, rre3, rempty3, ae3, ovf3, udf3;

    jtag_fifo_ctrl_sync_v2 u0 (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr0), .ram_wr_en(wre0), .wfull(wfull0),
        .almost_full(af0), .wr_water_level(wl0), .r_en(r_en), .raddr(raddr0), .ram_rd_en(rre0),
        .rempty(rempty0), .almost_empty(ae0), .rd_water_level(rl0), .af_level('0), .ae_level('0),
        .err_clr(err_clr), .overflow(ovf0), .underflow(udf0)
    );

    jtag_fifo_ctrl_sync_v2 #(.c_WR_DEPTH_WIDTH(10), .c_RD_DEPTH_WIDTH(9)) u1 (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr1), .ram_wr_en(wre1), .wfull(wfull1),
        .almost_full(af1), .wr_water_level(wl1), .r_en(r_en), .raddr(raddr1), .ram_rd_en(rre1),
        .rempty(rempty1), .almost_empty(ae1), .rd_water_level(rl1), .af_level('0), .ae_level('0),
        .err_clr(err_clr), .overflow(ovf1), .underflow(udf1)
    );

    jtag_fifo_ctrl_sync_v2 #(.c_WR_DEPTH_WIDTH(4), .c_RD_DEPTH_WIDTH(4), .c_RD_MODE("FWFT"),
                             .c_PROG_THRESH(1)) u2 (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr2), .ram_wr_en(wre2), .wfull(wfull2),
        .almost_full(af2), .wr_water_level(wl2), .r_en(r_en), .raddr(raddr2), .ram_rd_en(rre2),
        .rempty(rempty2), .almost_empty(ae2), .rd_water_level(rl2), .af_level(af_lvl), .ae_level(ae_lvl),
        .err_clr(err_clr), .overflow(ovf2), .underflow(udf2)
    );

    jtag_fifo_ctrl_sync_v2 #(.c_WR_DEPTH_WIDTH(4), .c_RD_DEPTH_WIDTH(4), .c_ALMOST_FULL_NUM(14),
                             .c_ALMOST_EMPTY_NUM(2)) u3 (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr3), .ram_wr_en(wre3), .wfull(wfull3),
        .almost_full(af3), .wr_water_level(wl3), .r_en(r_en), .raddr(raddr3), .ram_rd_en(rre3),
        .rempty(rempty3), .almost_empty(ae3), .rd_water_level(rl3), .af_level('0), .ae_level('0),
        .err_clr(err_clr), .overflow(ovf3), .underflow(udf3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // W=R=9 STD
        do_rst();
        chk("rst_wfull", wfull0, 0);
        chk("rst_rempty", rempty0, 1);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_wl", wl0, 0);
        chk("rst_rl", rl0, 0);
        chk("rst_waddr", waddr0, 0);
        chk("rst_ovf", ovf0, 0);
        w_en = 1; step(); w_en = 0;
        chk("wr1_rempty", rempty0, 0);
        chk("wr1_rl", rl0, 1);
        r_en = 1; step(); r_en = 0;
        chk("rd1_rempty", rempty0, 1);
        chk("rd1_raddr", raddr0, 1);
        chk("rd1_udf", udf0, 0);
        r_en = 1; step(); r_en = 0;
        chk("udf_set", udf0, 1);
        chk("udf_raddr", raddr0, 1);
        err_clr = 1; step(); err_clr = 0;
        chk("udf_clr", udf0, 0);
        w_en = 1;
        repeat (5) step();
        r_en = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("simul_lvl", wl0, 5);
        end
        r_en = 0;
        repeat (502) step();
        chk("lvl507_af", af0, 0);
        chk("lvl507_wl", wl0, 507);
        step();
        chk("lvl508_af", af0, 1);
        repeat (4) step();
        chk("full_wfull", wfull0, 1);
        chk("full_wl", wl0, 512);
        chk("full_rl", rl0, 512);
        chk("full_waddr", waddr0, 11);
        step();
        chk("ovf_set", ovf0, 1);
        chk("ovf_waddr", waddr0, 11);
        chk("ovf_wl", wl0, 512);
        r_en = 1; step(); w_en = 0; r_en = 0;
        chk("wr_rd_full_wfull", wfull0, 0);
        chk("wr_rd_full_wl", wl0, 511);
        chk("wr_rd_full_raddr", raddr0, 12);

        // W=10, R=9
        do_rst();
        w_en = 1; step();
        chk("r21_partial_rempty", rempty1, 1);
        chk("r21_partial_rl", rl1, 0);
        repeat (2) step(); w_en = 0;
        chk("r21_rl", rl1, 1);
        chk("r21_rempty", rempty1, 0);
        chk("r21_wl", wl1, 3);
        r_en = 1; step(); r_en = 0;
        chk("r21_rd_rl", rl1, 0);
        chk("r21_rd_rempty", rempty1, 1);
        chk("r21_rd_wl", wl1, 1);
        chk("r21_rd_ae", ae1, 1);

        // W=R=4 STD wrap
        do_rst();
        for (int c = 0; c < 3; c++) begin
            w_en = 1; repeat (16) step(); w_en = 0;
            chk("wrap_wfull", wfull3, 1);
            chk("wrap_wl", wl3, 16);
            chk("wrap_af", af3, 1);
            chk("wrap_waddr", waddr3, 0);
            r_en = 1; repeat (16) step(); r_en = 0;
            chk("wrap_rempty", rempty3, 1);
            chk("wrap_rl", rl3, 0);
            chk("wrap_wfull_clr", wfull3, 0);
            chk("wrap_raddr", raddr3, 0);
        end

        // W=R=4 FWFT, runtime thresholds
        ae_lvl = 5'd4;
        do_rst();
        w_en = 1; step(); w_en = 0;
        chk("fwft_lat1", rempty2, 1);
        step();
        chk("fwft_lat2", rempty2, 0);
        chk("fwft_rl1", rl2, 1);
        r_en = 1; step(); r_en = 0;
        chk("fwft_pop_rempty", rempty2, 1);
        chk("fwft_pop_udf", udf2, 0);
        chk("fwft_pop_rl", rl2, 0);
        w_en = 1; repeat (3) step();
        chk("fwft_pre_rl", rl2, 3);
        r_en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fwft_stream_rl", rl2, 3);
        end
        w_en = 0; r_en = 0;
        chk("fwft_stream_waddr", waddr2, 12);
        chk("fwft_stream_raddr", raddr2, 10);
        chk("fwft_stream_udf", udf2, 0);
        chk("fwft_ae_lvl4", ae2, 1);
        ae_lvl = 5'd2; step();
        chk("fwft_ae_lvl2", ae2, 0);
        r_en = 1; step(); r_en = 0;
        chk("fwft_ae_rd_rl", rl2, 2);
        chk("fwft_ae_rd", ae2, 1);
        r_en = 1; repeat (2) step(); r_en = 0;
        chk("fwft_drain_rempty", rempty2, 1);
        chk("fwft_drain_rl", rl2, 0);
        chk("fwft_drain_raddr", raddr2, 12);
        chk("fwft_drain_udf", udf2, 0);
        r_en = 1; step();
        chk("fwft_udf", udf2, 1);
        err_clr = 1; step(); r_en = 0;
        chk("fwft_set_wins", udf2, 1);
        step(); err_clr = 0;
        chk("fwft_udf_clr", udf2, 0);
        r_en = 1; step(); r_en = 0;
        w_en = 1; step(); w_en = 0;
        rst = 1; step();
        chk("mid_rst_waddr", waddr2, 0);
        chk("mid_rst_raddr", raddr2, 0);
        chk("mid_rst_rempty", rempty2, 1);
        chk("mid_rst_rl", rl2, 0);
        chk("mid_rst_wl", wl2, 0);
        chk("mid_rst_ae", ae2, 1);
        chk("mid_rst_af", af2, 0);
        chk("mid_rst_udf", udf2, 0);
        chk("mid_rst_rre", rre2, 0);
        rst = 0; step();
        chk("post_rst_rempty", rempty2, 1);
        chk("post_rst_rl", rl2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_fifo_ctrl_sync_v2.md
Name: jtag_fifo_ctrl_sync_v2

Overview:
- Single-clock FIFO pointer/flag controller. It is the synchronous successor of the JTAG shift FIFO controller.
- Adds asymmetric width ratio in either direction, a first-word-fall-through (FWFT) read mode, runtime-programmable almost thresholds and sticky overflow/underflow error flags.
- Drives the address/enable ports of an external simple dual-port RAM whose read port has a registered output with clock enable.
- Sits between the JTAG shift engine and user logic.

Parameters:
- c_WR_DEPTH_WIDTH, 9: log2 write-side depth in write words.
- c_RD_DEPTH_WIDTH, 9: log2 read-side depth in read words. |c_WR_DEPTH_WIDTH-c_RD_DEPTH_WIDTH| <= 4.
- c_RD_MODE, "STD": "STD" or "FWFT".
- c_PROG_THRESH, 0: 0 = use the parameter thresholds below; 1 = use the af_level/ae_level ports.
- c_ALMOST_FULL_NUM, 508: almost-full threshold in write words.
- c_ALMOST_EMPTY_NUM, 4: almost-empty threshold in read words.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- waddr  out  c_WR_DEPTH_WIDTH  RAM write address.
- ram_wr_en  out  1  w_en & !wfull.
- wfull  out  1  full flag.
- almost_full  out  1  wr_water_level >= AF threshold.
- wr_water_level  out  c_WR_DEPTH_WIDTH+1  occupancy in write words.
- r_en  in  1  read request (STD) / pop (FWFT).
- raddr  out  c_RD_DEPTH_WIDTH  RAM read address.
- ram_rd_en  out  1  RAM output-register clock enable.
- rempty  out  1  empty flag (no valid read data).
- almost_empty  out  1  rd_water_level <= AE threshold.
- rd_water_level  out  c_RD_DEPTH_WIDTH+1  occupancy in read words.
- af_level  in  c_WR_DEPTH_WIDTH+1  runtime AF threshold; ignored when c_PROG_THRESH=0.
- ae_level  in  c_RD_DEPTH_WIDTH+1  runtime AE threshold; ignored when c_PROG_THRESH=0.
- err_clr  in  1  clears the sticky error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset: at any clk edge with rst=1, all of the following take these values the same edge, aborting any pending FWFT prefetch:
  - wbin=rbin=0, waddr=raddr=0.
  - wfull=0, rempty=1.
  - almost_full=0, almost_empty=1.
  - levels=0, overflow=underflow=0, out_valid=0.
- Pointers:
  - Binary wbin is c_WR_DEPTH_WIDTH+1 bits; rbin is c_RD_DEPTH_WIDTH+1 bits.
  - waddr=wbin[W-1:0], raddr=rbin[R-1:0].
  - wbin increments when ram_wr_en; wraps modulo 2^(W+1).
- Width alignment:
  - Let D=|W-R|. The pointer of the shallower side is left-shifted by D for comparisons on the deeper side's scale.
  - The deeper side's pointer is truncated (top bits kept) for the shallower side's scale.
  - A partial wide word is never counted as readable.
- Flags:
  - All flags are registered from next-pointer values, so each flag reflects the state after the current edge.
  - Full when the aligned MSBs differ and the lower bits are equal.
  - Core-empty when the aligned pointers are equal.
  - Simultaneous write and read at full: the write is blocked and the read proceeds, so wfull clears next edge.
  - Simultaneous write and read at empty (STD): the read is blocked and the write proceeds.
- Levels: modulo-2^(N+1) difference of the aligned next pointers, registered.
  - wr_water_level is in write words.
  - rd_water_level is in read words; in FWFT mode it adds out_valid.
- Almost flags:
  - Registered comparisons against the selected threshold.
  - Runtime threshold changes take effect on the next edge.
- STD mode:
  - ram_rd_en = r_en & !rempty; rbin increments on it.
  - Data appears on the RAM output the cycle after the read edge.
  - rempty = core-empty.
- FWFT mode:
  - ram_rd_en = !core_empty & (!out_valid | r_en).
  - rbin increments on ram_rd_en.
  - out_valid is set at an edge with ram_rd_en, and cleared at an edge with r_en & out_valid & !ram_rd_en.
  - rempty = !out_valid. r_en while out_valid=0 is an underflow and has no other effect.
- Latency from the write edge to rempty falling: 1 edge (STD), 2 edges (FWFT).
- Errors:
  - overflow sets on w_en&wfull; underflow sets on r_en&rempty.
  - err_clr clears both; a simultaneous set wins over clear.

Test Plan:
- W=R=9 STD: reset, write 512 words → wfull=1 after the 512th edge, wr_water_level=512, almost_full=1 from level 508; 513th write → overflow=1, wbin unchanged.
- W=R=9 STD: write 1, read 1 → rempty falls 1 edge after the write, rises after the read; simultaneous w_en/r_en at level 5 → level stays 5 for 10 cycles.
- W=10,R=9 (2:1): write 3 narrow words → rd_water_level=1, rempty=0; read 1 → rd_water_level=0, rempty=1, wr_water_level=1.
- FWFT W=R=4: write 1 word → rempty=0 two edges later with no r_en; r_en held high while writing 1 word/cycle → one pop per cycle, no underflow.
- Wrap: 3 full fill/drain cycles at W=R=4 → pointers wrap, flags correct, levels never exceed 16.
- c_PROG_THRESH=1: ae_level=2 set mid-run at level 3 → almost_empty=0; read 1 → almost_empty=1 next edge; assert rst mid-FWFT-prefetch → all outputs at reset values that edge.
